// File: rtl/pwm_deadtime_gen.sv
// Three-phase complementary gate-drive generator with per-leg dead-time FSMs
// and a sticky fault latch fed by timing_hub and the async driver fault pin.

module pwm_leg #(
   parameter int DEADTIME = 16
) (
   input  logic clk_ctrl,
   input  logic rst_n,
   input  logic enabled,
   input  logic dem_hi,
   output logic inh,
   output logic inl,
   output logic active
);
   localparam int DTW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
   localparam logic [DTW-1:0] DT_LOAD = DTW'(DEADTIME - 1);

   typedef enum logic [1:0] {S_OFF, S_DT, S_HI, S_LO} leg_state_e;

   leg_state_e     state_q, state_d;
   logic [DTW-1:0] dt_cnt_q, dt_cnt_d;
   logic           inh_q, inh_d, inl_q, inl_d;

   always_comb begin
      state_d  = state_q;
      dt_cnt_d = dt_cnt_q;
      if (!enabled) begin
         state_d = S_OFF;
      end else begin
         case (state_q)
            S_OFF: begin
               state_d  = S_DT;
               dt_cnt_d = DT_LOAD;
            end
            // demand is only sampled at exit, so toggles inside the window never restart it
            S_DT: begin
               if (dt_cnt_q == '0) state_d = dem_hi ? S_HI : S_LO;
               else                dt_cnt_d = dt_cnt_q - DTW'(1);
            end
            S_HI: begin
               if (!dem_hi) begin
                  state_d  = S_DT;
                  dt_cnt_d = DT_LOAD;
               end
            end
            S_LO: begin
               if (dem_hi) begin
                  state_d  = S_DT;
                  dt_cnt_d = DT_LOAD;
               end
            end
            default: state_d = S_OFF;
         endcase
      end
      inh_d = (state_d == S_HI);
      inl_d = (state_d == S_LO);
   end

   always_ff @(posedge clk_ctrl or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_OFF;
         dt_cnt_q <= '0;
         inh_q    <= 1'b0;
         inl_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         dt_cnt_q <= dt_cnt_d;
         inh_q    <= inh_d;
         inl_q    <= inl_d;
      end
   end

   assign inh    = inh_q;
   assign inl    = inl_q;
   assign active = (state_q != S_OFF);
endmodule

module pwm_deadtime_gen #(
   parameter int CTR_W       = 12,
   parameter int DEADTIME    = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_ctrl,
   input  logic             rst_n,
   input  logic [CTR_W-1:0] pwm_ctr,
   input  logic             pwm_ctr_en,
   input  logic [CTR_W-1:0] duty_a,
   input  logic [CTR_W-1:0] duty_b,
   input  logic [CTR_W-1:0] duty_c,
   input  logic             duty_wr,
   input  logic             arm,
   input  logic             hub_fault,
   input  logic             nfault,
   input  logic             fault_clr,
   output logic             inha,
   output logic             inla,
   output logic             inhb,
   output logic             inlb,
   output logic             inhc,
   output logic             inlc,
   output logic             fault_latched,
   output logic             running
);
   localparam int NUM_LEGS = 3;

   logic [NUM_LEGS-1:0][CTR_W-1:0] duty_in, pend_q, pend_d, act_q, act_d;
   logic [NUM_LEGS-1:0]            dem_q, dem_d;
   logic [SYNC_STAGES-1:0]         nf_sync_q, nf_sync_d;
   logic                           fault_q, fault_d;
   logic [NUM_LEGS-1:0]            leg_inh, leg_inl, leg_act;
   logic                           nfault_s, period_start, enabled;

   assign duty_in      = {duty_c, duty_b, duty_a};
   assign period_start = pwm_ctr_en && (pwm_ctr == '0);
   assign nfault_s     = nf_sync_q[SYNC_STAGES-1];
   assign enabled      = arm && !fault_q;

   always_comb begin
      pend_d = duty_wr ? duty_in : pend_q;
      // pend_d forwards a write landing on the period-start cycle straight into active
      act_d  = period_start ? pend_d : act_q;
      dem_d  = dem_q;
      // compare against act_d so counter 0 of a new period already sees the new duty
      for (int i = 0; i < NUM_LEGS; i++)
         if (pwm_ctr_en) dem_d[i] = (act_d[i] > pwm_ctr);
   end

   always_comb begin
      nf_sync_d[0] = nfault;
      for (int i = 1; i < SYNC_STAGES; i++) nf_sync_d[i] = nf_sync_q[i-1];
      fault_d = fault_q;
      if (fault_clr && !hub_fault && nfault_s && !arm) fault_d = 1'b0;
      if (hub_fault || !nfault_s)                      fault_d = 1'b1;
   end

   always_ff @(posedge clk_ctrl or negedge rst_n) begin
      if (!rst_n) begin
         pend_q    <= '0;
         act_q     <= '0;
         dem_q     <= '0;
         nf_sync_q <= '1;
         fault_q   <= 1'b0;
      end else begin
         pend_q    <= pend_d;
         act_q     <= act_d;
         dem_q     <= dem_d;
         nf_sync_q <= nf_sync_d;
         fault_q   <= fault_d;
      end
   end

   pwm_leg #(.DEADTIME(DEADTIME)) u_leg [NUM_LEGS-1:0] (
      .clk_ctrl (clk_ctrl),
      .rst_n    (rst_n),
      .enabled  ({NUM_LEGS{enabled}}),
      .dem_hi   (dem_q),
      .inh      (leg_inh),
      .inl      (leg_inl),
      .active   (leg_act)
   );

   // fault gating covers the edge where the latch sets, before the legs reach OFF
   assign inha = leg_inh[0] & ~fault_q;
   assign inla = leg_inl[0] & ~fault_q;
   assign inhb = leg_inh[1] & ~fault_q;
   assign inlb = leg_inl[1] & ~fault_q;
   assign inhc = leg_inh[2] & ~fault_q;
   assign inlc = leg_inl[2] & ~fault_q;

   assign fault_latched = fault_q;
   assign running       = enabled && (&leg_act);
endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Directed bench for pwm_deadtime_gen: duty/dead-time windows, deferred duty
// update, steady rails, demand toggles in dead time, fault latch, async reset.

module tb_pwm_deadtime_gen;
   logic        clk_ctrl = 1'b0;
   logic        rst_n;
   logic [11:0] pwm_ctr, duty_a, duty_b, duty_c, ctr_max, smp;
   logic        pwm_ctr_en, duty_wr, arm, hub_fault, nfault, fault_clr;
   logic        inha, inla, inhb, inlb, inhc, inlc, fault_latched, running;
   logic [5:0]  gates;
   logic        run_ctr;
   int          n_vec = 0, n_err = 0;

   assign gates = {inha, inla, inhb, inlb, inhc, inlc};

   always #5 clk_ctrl = ~clk_ctrl;

   pwm_deadtime_gen #(.CTR_W(12), .DEADTIME(16), .SYNC_STAGES(2)) dut (
      .clk_ctrl(clk_ctrl), .rst_n(rst_n), .pwm_ctr(pwm_ctr), .pwm_ctr_en(pwm_ctr_en),
      .duty_a(duty_a), .duty_b(duty_b), .duty_c(duty_c), .duty_wr(duty_wr),
      .arm(arm), .hub_fault(hub_fault), .nfault(nfault), .fault_clr(fault_clr),
      .inha(inha), .inla(inla), .inhb(inhb), .inlb(inlb), .inhc(inhc), .inlc(inlc),
      .fault_latched(fault_latched), .running(running)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk_ctrl);
         #1;
         smp = pwm_ctr;
         if (run_ctr) pwm_ctr = (pwm_ctr == ctr_max) ? 12'd0 : pwm_ctr + 12'd1;
         chk("overlap", {29'd0, inha & inla, inhb & inlb, inhc & inlc}, 32'd0);
      end
   endtask

   task automatic adv_to(input logic [11:0] c);
      int k;
      k = 0;
      do begin
         cyc(1);
         k++;
      end while (smp != c && k < 10000);
      if (smp != c) chk("timeout", {20'd0, smp}, {20'd0, c});
   endtask

   initial begin
      rst_n = 1'b1; pwm_ctr = 12'd100; pwm_ctr_en = 1'b1; ctr_max = 12'd4095; run_ctr = 1'b0;
      duty_a = '0; duty_b = '0; duty_c = '0; duty_wr = 1'b0; smp = '0;
      arm = 1'b0; hub_fault = 1'b0; nfault = 1'b1; fault_clr = 1'b0;
      #2 rst_n = 1'b0;
      cyc(3);
      chk("rst_gates", gates, 6'b0);
      chk("rst_fault", fault_latched, 1'b0);
      chk("rst_running", running, 1'b0);
      rst_n = 1'b1;
      cyc(2);

      // pending write mid-period: active stays 0, all legs settle low
      duty_a = 12'd1024; duty_b = 12'd0; duty_c = 12'd0; duty_wr = 1'b1;
      cyc(1);
      duty_wr = 1'b0;
      arm = 1'b1;
      cyc(1);
      chk("arm_running", running, 1'b1);
      chk("arm_dt_start", gates, 6'b000000);
      cyc(15);
      chk("arm_dt_end", gates, 6'b000000);
      cyc(1);
      chk("arm_first_lo", gates, 6'b010101);

      // 1024 duty over a full 0..4095 ramp
      run_ctr = 1'b1;
      adv_to(12'd0);    chk("p1_c0", gates, 6'b010101);
      adv_to(12'd1);    chk("p1_c1", gates, 6'b000101);
      adv_to(12'd16);   chk("p1_c16", gates, 6'b000101);
      adv_to(12'd17);   chk("p1_c17", gates, 6'b100101);
      adv_to(12'd500);  chk("p1_c500", gates, 6'b100101);
      duty_a = 12'd2000; duty_wr = 1'b1;
      cyc(1);
      duty_wr = 1'b0;
      adv_to(12'd1024); chk("p1_c1024", gates, 6'b100101);
      adv_to(12'd1025); chk("p1_c1025", gates, 6'b000101);
      adv_to(12'd1040); chk("p1_c1040", gates, 6'b000101);
      adv_to(12'd1041); chk("p1_c1041", gates, 6'b010101);
      adv_to(12'd1500); chk("p1_c1500", gates, 6'b010101);
      adv_to(12'd4095); chk("p1_c4095", gates, 6'b010101);

      // next period picks up 2000
      adv_to(12'd0);    chk("p2_c0", gates, 6'b010101);
      adv_to(12'd1);    chk("p2_c1", gates, 6'b000101);
      adv_to(12'd17);   chk("p2_c17", gates, 6'b100101);
      adv_to(12'd1030); chk("p2_c1030", gates, 6'b100101);
      adv_to(12'd2000); chk("p2_c2000", gates, 6'b100101);
      adv_to(12'd2001); chk("p2_c2001", gates, 6'b000101);
      adv_to(12'd2016); chk("p2_c2016", gates, 6'b000101);
      adv_to(12'd2017); chk("p2_c2017", gates, 6'b010101);

      // demand 1 -> 0 -> 1 inside dead time: exit after exactly 16 cycles to high
      run_ctr = 1'b0;
      pwm_ctr = 12'd100;
      cyc(1);
      cyc(1);           chk("tog_dt", gates, 6'b000101);
      cyc(1);
      pwm_ctr = 12'd3000;
      cyc(1);
      cyc(1);
      pwm_ctr = 12'd100;
      cyc(1);
      cyc(11);          chk("tog_dt_last", gates, 6'b000101);
      cyc(1);           chk("tog_exit_hi", gates, 6'b100101);

      // duty 4095 with counter max 4094 holds phase c high across the wrap
      duty_c = 12'd4095; duty_wr = 1'b1;
      cyc(1);
      duty_wr = 1'b0;
      ctr_max = 12'd4094; run_ctr = 1'b1;
      adv_to(12'd0);
      adv_to(12'd1);    chk("c_dt", {inhc, inlc}, 2'b00);
      adv_to(12'd17);   chk("c_hi17", {inhc, inlc}, 2'b10);
      adv_to(12'd4094); chk("c_hi_max", {inhc, inlc}, 2'b10);
                        chk("b_lo_max", {inhb, inlb}, 2'b01);
      adv_to(12'd0);    chk("c_hi_wrap", {inhc, inlc}, 2'b10);
      adv_to(12'd20);   chk("c_hi20", {inhc, inlc}, 2'b10);

      // nfault mid-period
      adv_to(12'd1000); chk("pre_fault", gates, 6'b100110);
      nfault = 1'b0;
      cyc(2);           chk("nf_sync_wait", fault_latched, 1'b0);
      cyc(1);           chk("nf_latched", fault_latched, 1'b1);
                        chk("nf_gates", gates, 6'b000000);
                        chk("nf_running", running, 1'b0);
      nfault = 1'b1;
      cyc(3);
      fault_clr = 1'b1;
      cyc(1);
      fault_clr = 1'b0; chk("clr_armed_ignored", fault_latched, 1'b1);
      arm = 1'b0; fault_clr = 1'b1;
      cyc(1);
      fault_clr = 1'b0; chk("clr_disarmed", fault_latched, 1'b0);
                        chk("clr_gates", gates, 6'b000000);
      hub_fault = 1'b1;
      cyc(1);           chk("hub_set", fault_latched, 1'b1);
      fault_clr = 1'b1;
      cyc(1);           chk("hub_set_wins", fault_latched, 1'b1);
      hub_fault = 1'b0;
      cyc(1);
      fault_clr = 1'b0; chk("hub_clr", fault_latched, 1'b0);

      // re-arm: full dead time before first turn-on
      run_ctr = 1'b0;
      pwm_ctr = 12'd3000;
      cyc(2);
      arm = 1'b1;
      cyc(1);           chk("rearm_running", running, 1'b1);
                        chk("rearm_dt", gates, 6'b000000);
      cyc(15);          chk("rearm_dt_end", gates, 6'b000000);
      cyc(1);           chk("rearm_on", gates, 6'b010110);

      // async reset while inha is high
      pwm_ctr = 12'd100;
      cyc(18);          chk("pre_rst_hi", gates, 6'b100110);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_gates", gates, 6'b000000);
      chk("async_rst_running", running, 1'b0);
      arm = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      cyc(3);           chk("post_rst_gates", gates, 6'b000000);
                        chk("post_rst_running", running, 1'b0);
      arm = 1'b1;
      cyc(17);          chk("post_rst_active0", gates, 6'b010101);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
